// File: rtl/axi_lite_pkg.sv
// ============================================================================
// Module : axi_lite_pkg
// Brief  : Shared FSM state encoding and AXI response codes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package axi_lite_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        WAIT_B = 3'd2,
        READ   = 3'd3,
        WAIT_R = 3'd4,
        RESP   = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

`default_nettype wire

// File: rtl/axi_lite_master.sv
// ============================================================================
// Module : axi_lite_master
// Brief  : Single-outstanding AXI4-Lite master driven by a cmd/rsp handshake.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                ACLK,
    input  logic                ARESETn,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,

    output logic [ADDR_W-1:0]   M_AXI_AWADDR,
    output logic                M_AXI_AWVALID,
    input  logic                M_AXI_AWREADY,

    output logic [DATA_W-1:0]   M_AXI_WDATA,
    output logic [DATA_W/8-1:0] M_AXI_WSTRB,
    output logic                M_AXI_WVALID,
    input  logic                M_AXI_WREADY,

    input  logic [1:0]          M_AXI_BRESP,
    input  logic                M_AXI_BVALID,
    output logic                M_AXI_BREADY,

    output logic [ADDR_W-1:0]   M_AXI_ARADDR,
    output logic                M_AXI_ARVALID,
    input  logic                M_AXI_ARREADY,

    input  logic [DATA_W-1:0]   M_AXI_RDATA,
    input  logic [1:0]          M_AXI_RRESP,
    input  logic                M_AXI_RVALID,
    output logic                M_AXI_RREADY
);

    state_t                state;
    state_t                state_next;

    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wstrb_q;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  arvalid_q;
    logic [DATA_W-1:0]     rdata_q;
    logic [1:0]            resp_q;

    logic                  accept;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  b_hs;
    logic                  r_hs;

    assign accept = (state == IDLE) && cmd_valid;
    assign aw_hs  = awvalid_q && M_AXI_AWREADY;
    assign w_hs   = wvalid_q && M_AXI_WREADY;
    assign ar_hs  = arvalid_q && M_AXI_ARREADY;
    assign b_hs   = (state == WAIT_B) && M_AXI_BVALID;
    assign r_hs   = (state == WAIT_R) && M_AXI_RVALID;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (cmd_valid)     state_next = cmd_write ? WRITE : READ;
            // Each channel is finished if it already handshook or does so now.
            WRITE:  if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY))
                                       state_next = WAIT_B;
            WAIT_B: if (M_AXI_BVALID)  state_next = RESP;
            READ:   if (ar_hs)         state_next = WAIT_R;
            WAIT_R: if (M_AXI_RVALID)  state_next = RESP;
            RESP:   if (rsp_ready)     state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
        end else begin
            if (accept) begin
                addr_q    <= cmd_addr;
                wdata_q   <= cmd_wdata;
                wstrb_q   <= cmd_wstrb;
                awvalid_q <= cmd_write;
                wvalid_q  <= cmd_write;
                arvalid_q <= !cmd_write;
            end
            if (aw_hs) awvalid_q <= 1'b0;
            if (w_hs)  wvalid_q  <= 1'b0;
            if (ar_hs) arvalid_q <= 1'b0;
            if (b_hs) begin
                rdata_q <= '0;
                resp_q  <= M_AXI_BRESP;
            end
            if (r_hs) begin
                rdata_q <= M_AXI_RDATA;
                resp_q  <= M_AXI_RRESP;
            end
        end
    end

    assign cmd_ready     = (state == IDLE);
    assign rsp_valid     = (state == RESP);
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = (state == WAIT_B);
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = (state == WAIT_R);

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_master.sv
// ============================================================================
// Module : tb_axi_lite_master
// Brief  : Directed self-checking bench with a delay-configurable AXI slave.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_axi_lite_master;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] AWADDR, WDATA, ARADDR;
    logic [31:0] RDATA = '0;
    logic [3:0]  WSTRB;
    logic        AWVALID, WVALID, ARVALID, BREADY, RREADY;
    logic        AWREADY = 1'b0, WREADY = 1'b0, ARREADY = 1'b0;
    logic        BVALID = 1'b0, RVALID = 1'b0;
    logic [1:0]  BRESP = '0, RRESP = '0;

    always #5 ACLK = ~ACLK;

    axi_lite_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_AWADDR(AWADDR), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
        .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
        .M_AXI_ARADDR(ARADDR), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Slave configuration and observation
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = '0;
    int          aw_wait = 0, w_wait = 0, ar_wait = 0;
    bit          aw_done = 0, w_done = 0, b_pend = 0, r_pend = 0, w_held = 0, w_unstable = 0;
    int          aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0, aw_extra = 0, w_extra = 0;
    logic [31:0] aw_addr_seen = '0, w_data_seen = '0, ar_addr_seen = '0, w_first = '0;
    logic [3:0]  w_strb_seen = '0;

    task automatic clr();
        aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0;
        aw_extra = 0; w_extra = 0; w_unstable = 0;
    endtask

    // Decisions at negedge take effect at the following posedge.
    always @(negedge ACLK) begin
        if (!ARESETn) begin
            AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0;
            aw_done = 0; w_done = 0; b_pend = 0; r_pend = 0; w_held = 0;
        end else begin
            if (b_pend) begin
                BVALID = 1; BRESP = bresp_cfg;
                if (BREADY) begin b_pend = 0; b_hs++; end
            end else BVALID = 0;
            if (r_pend) begin
                RVALID = 1; RDATA = rdata_cfg; RRESP = rresp_cfg;
                if (RREADY) begin r_pend = 0; r_hs++; end
            end else begin
                RVALID = 0; RDATA = 32'h0BAD_F00D;
            end
            AWREADY = 0;
            if (AWVALID) begin
                if (aw_done) aw_extra++;
                if (aw_wait >= aw_delay) begin
                    AWREADY = 1; aw_hs++; aw_addr_seen = AWADDR; aw_wait = 0; aw_done = 1;
                end else aw_wait++;
            end
            WREADY = 0;
            if (WVALID) begin
                if (w_done) w_extra++;
                if (w_held && (WDATA !== w_first)) w_unstable = 1;
                if (!w_held) w_first = WDATA;
                w_held = 1;
                if (w_wait >= w_delay) begin
                    WREADY = 1; w_hs++; w_data_seen = WDATA; w_strb_seen = WSTRB;
                    w_wait = 0; w_done = 1; w_held = 0;
                end else w_wait++;
            end
            ARREADY = 0;
            if (ARVALID) begin
                if (ar_wait >= ar_delay) begin
                    ARREADY = 1; ar_hs++; ar_addr_seen = ARADDR; ar_wait = 0; r_pend = 1;
                end else ar_wait++;
            end
            if (aw_done && w_done) begin aw_done = 0; w_done = 0; b_pend = 1; end
        end
    end

    task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [31:0] exp_rdata,
                           input logic [1:0] exp_resp, input int exp_lat, input int hold,
                           input string tag);
        int n;
        int lat;
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        n = 0;
        while (!cmd_ready && n < 50) begin @(posedge ACLK); #1; n++; end
        chk({tag, " cmd_ready"}, cmd_ready, 1);
        @(posedge ACLK); #1;
        cmd_valid = 0;
        lat = 1;
        while (!rsp_valid && lat < 100) begin @(posedge ACLK); #1; lat++; end
        chk({tag, " rsp_valid"}, rsp_valid, 1);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " rsp_rdata"}, rsp_rdata, exp_rdata);
        chk({tag, " rsp_resp"}, rsp_resp, exp_resp);
        for (int i = 0; i < hold; i++) begin
            @(posedge ACLK); #1;
            chk({tag, " hold"},
                {rsp_valid, cmd_ready, AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_resp, rsp_rdata},
                {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_resp, exp_rdata});
        end
        rsp_ready = 1;
        @(posedge ACLK); #1;
        rsp_ready = 0;
        chk({tag, " idle after rsp"}, {rsp_valid, cmd_ready}, 2'b01);
    endtask

    initial begin
        repeat (2) @(posedge ACLK);
        #1;
        chk("reset outputs",
            {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, rsp_resp, rsp_rdata, AWADDR, WDATA, WSTRB},
            '0);
        ARESETn = 1;
        @(posedge ACLK); #1;
        chk("cmd_ready after reset", cmd_ready, 1);

        // Immediate-ready write
        clr(); aw_delay = 0; w_delay = 0; bresp_cfg = 2'b00;
        run_cmd(1, 32'h08, 32'h0000_1234, 4'hF, 32'h0, 2'b00, 3, 0, "wr1");
        chk("wr1 aw_hs", aw_hs, 1);
        chk("wr1 w_hs", w_hs, 1);
        chk("wr1 b_hs", b_hs, 1);
        chk("wr1 awaddr", aw_addr_seen, 32'h08);
        chk("wr1 wdata", {w_strb_seen, w_data_seen}, {4'hF, 32'h0000_1234});

        // AWREADY three cycles ahead of WREADY
        clr(); aw_delay = 0; w_delay = 3;
        run_cmd(1, 32'h0C, 32'hA5A5_0001, 4'b0011, 32'h0, 2'b00, 6, 0, "wr2");
        chk("wr2 hs counts", {aw_hs[7:0], w_hs[7:0], b_hs[7:0]}, 24'h010101);
        chk("wr2 valid after hs", {aw_extra[7:0], w_extra[7:0]}, 16'h0);
        chk("wr2 wdata stable", w_unstable, 0);
        chk("wr2 wdata", {w_strb_seen, w_data_seen}, {4'b0011, 32'hA5A5_0001});

        // Reads: OKAY then SLVERR with a stalled response consumer
        clr(); rdata_cfg = 32'hDEAD_BEEF; rresp_cfg = 2'b00;
        run_cmd(0, 32'h20, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00, 3, 0, "rd1");
        chk("rd1 araddr", ar_addr_seen, 32'h20);
        chk("rd1 ar/r hs", {ar_hs[7:0], r_hs[7:0], aw_hs[7:0]}, 24'h010100);
        clr(); rdata_cfg = 32'h1111_2222; rresp_cfg = 2'b10;
        run_cmd(0, 32'h24, 32'h0, 4'h0, 32'h1111_2222, 2'b10, 3, 5, "rd2");
        chk("rd2 ar_hs", ar_hs, 1);

        // DECERR write with late AWREADY; also clears previous read data
        clr(); aw_delay = 2; w_delay = 0; bresp_cfg = 2'b11;
        run_cmd(1, 32'h40, 32'h5555_AAAA, 4'b1000, 32'h0, 2'b11, 5, 0, "wr3");
        chk("wr3 awaddr", aw_addr_seen, 32'h40);

        // Reset while both write VALIDs are pending
        clr(); aw_delay = 10; w_delay = 10;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h50; cmd_wdata = 32'h7777_0000; cmd_wstrb = 4'hF;
        @(posedge ACLK); #1;
        cmd_valid = 0;
        @(posedge ACLK); #1;
        chk("mid-write valids", {AWVALID, WVALID}, 2'b11);
        ARESETn = 0;
        #1;
        chk("async reset valids", {AWVALID, WVALID, rsp_valid, AWADDR}, '0);
        @(posedge ACLK); #1;
        ARESETn = 1;
        @(posedge ACLK); #1;
        chk("cmd_ready after mid reset", cmd_ready, 1);
        clr(); aw_delay = 0; w_delay = 0; rdata_cfg = 32'hCAFE_F00D; rresp_cfg = 2'b00;
        run_cmd(0, 32'h30, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b00, 3, 0, "rd3");
        chk("rd3 no write hs", {aw_hs[7:0], w_hs[7:0], b_hs[7:0]}, 24'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_W, default 32, AXI data width (32 only supported).
REQ-003 SHALL have port ACLK  input  1  sole clock, rising edge.
REQ-004 SHALL have port ARESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-008 SHALL have port cmd_addr  input  ADDR_W  target byte address.
REQ-009 SHALL have port cmd_wdata  input  DATA_W  write data.
REQ-010 SHALL have port cmd_wstrb  input  DATA_W/8  write byte strobes.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-013 SHALL have port rsp_rdata  output  DATA_W  read data; 0 for writes.
REQ-014 SHALL have port rsp_resp  output  2  BRESP or RRESP of the completed transaction.
REQ-015 SHALL have ports M_AXI_AWADDR out ADDR_W, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1: write address channel.
REQ-016 SHALL have ports M_AXI_WDATA out DATA_W, M_AXI_WSTRB out DATA_W/8, M_AXI_WVALID out 1, M_AXI_WREADY in 1: write data channel.
REQ-017 SHALL have ports M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1: write response channel.
REQ-018 SHALL have ports M_AXI_ARADDR out ADDR_W, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1: read address channel.
REQ-019 SHALL have ports M_AXI_RDATA in DATA_W, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1: read data channel.

Function
REQ-020 SHALL implement FSM states IDLE, WRITE, WAIT_B, READ, WAIT_R, RESP; one transaction outstanding at a time.
REQ-021 SHALL drive cmd_ready = 1 only in IDLE; on cmd_valid&cmd_ready, latch addr/wdata/wstrb and go to WRITE (cmd_write=1) or READ (cmd_write=0).
REQ-022 In WRITE, SHALL assert AWVALID and WVALID from the cycle after acceptance, each registered and dropped independently on the cycle after its own VALID&READY handshake; go to WAIT_B once both handshakes are done, including same-cycle completion.
REQ-023 SHALL never deassert any VALID before its handshake, never change AW/W/AR payloads while VALID is high, and never wait on READY before asserting VALID.
REQ-024 In WAIT_B, SHALL hold BREADY = 1; on BVALID, capture BRESP, set rsp_rdata = 0, go to RESP.
REQ-025 In READ, SHALL assert ARVALID until ARVALID&ARREADY, then go to WAIT_R.
REQ-026 In WAIT_R, SHALL hold RREADY = 1; on RVALID, capture RDATA and RRESP, go to RESP.
REQ-027 In RESP, SHALL hold rsp_valid = 1 with stable rsp_rdata/rsp_resp until rsp_ready, then return to IDLE; minimum command-to-response latency is 3 cycles.
REQ-028 SHALL pass SLVERR/DECERR responses unmodified in rsp_resp; no retry.
REQ-029 SHALL keep BREADY/RREADY = 0 outside WAIT_B/WAIT_R; stray BVALID/RVALID in other states SHALL be ignored.

Reset
REQ-030 On ARESETn low, asynchronously and regardless of state, SHALL return to IDLE with all AXI VALID/READY outputs, rsp_valid, rsp_rdata, rsp_resp and latched payloads at 0; cmd_ready = 1 on the first clock after release.

Structure
REQ-031 SHALL place FSM state encoding and AXI response constants (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11) in shared package axi_lite_pkg.
REQ-032 SHALL be a single module with no sub-modules.

Verification
REQ-033 Write 0x08 <- 0x0000_1234, slave ready immediately, BRESP=00 -> one AW and one W handshake, rsp_valid with rsp_resp=00, rsp_rdata=0.
REQ-034 Write where AWREADY arrives 3 cycles before WREADY -> AWVALID drops after its handshake, WVALID held with stable data until WREADY, single response.
REQ-035 Read 0x20, slave returns RDATA=0xDEADBEEF, RRESP=00 -> rsp_rdata=0xDEADBEEF, rsp_resp=00; slave returns RRESP=10 -> rsp_resp=10.
REQ-036 rsp_ready held low 5 cycles -> rsp_valid and data stable, cmd_ready=0 throughout, no new AXI VALID.
REQ-037 ARESETn low mid-WRITE with AWVALID/WVALID high -> both drop immediately; after release cmd_ready=1 and next read completes normally.
